// File: rtl/jtag_mem_ap_pkg.sv
// Shared types and constants for the JTAG MEM-AP: register offsets, CSW layout, FSM states,
// bus size encodings and the abort read-data pattern.
package jtag_mem_ap_pkg;

    // AP register word addresses (byte offset >> 2)
    localparam logic [5:0] AddrCsw = 6'h00;
    localparam logic [5:0] AddrTar = 6'h01;
    localparam logic [5:0] AddrDrw = 6'h03;
    localparam logic [5:0] AddrIdr = 6'h3F;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;
    localparam logic [1:0] SizeRsvd = 2'd3;

    localparam logic [1:0] IncSingle = 2'b01;

    localparam logic [2:0] AckOk   = 3'b010;
    localparam logic [2:0] AckWait = 3'b001;

    localparam logic [31:0] AbortRdata = 32'hdead_dead;

    typedef struct packed {
        logic [1:0] addrinc;
        logic [1:0] size;
    } csw_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRel
    } mem_ap_state_e;

    // Auto-increment stays inside the current 1 KB block.
    function automatic logic [31:0] tar_inc(input logic [31:0] tar, input logic [1:0] size);
        logic [9:0] step;
        step = 10'd1 << size;
        return {tar[31:10], tar[9:0] + step};
    endfunction

endpackage

// File: rtl/jtag_mem_ap_if.sv
// 4-phase req/ack memory bus between the MEM-AP (master) and the system-clock bus bridge (slave).
interface jtag_mem_ap_if;

    logic        m_req;
    logic        m_ack;
    logic [31:0] m_addr;
    logic        m_write;
    logic [1:0]  m_size;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_slverr;

    modport master (
        output m_req, m_addr, m_write, m_size, m_wdata,
        input  m_ack, m_rdata, m_slverr
    );

    modport slave (
        input  m_req, m_addr, m_write, m_size, m_wdata,
        output m_ack, m_rdata, m_slverr
    );

endinterface

// File: rtl/jtag_mem_ap_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module jtag_mem_ap_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/jtag_mem_ap.sv
// MEM-AP on tck: decodes AP register accesses and runs DRW/BDx as 4-phase bus transactions.
// Optional REQ timeout abort is enabled by defining DBG_MEM_AP_TIMEOUT_EN.
module jtag_mem_ap
    import jtag_mem_ap_pkg::*;
#(
    parameter logic [7:0]  AP_SEL      = 8'h00,
    parameter logic [31:0] AP_IDR      = 32'h0477_0002,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        tck,
    input  logic        trstn,
    input  logic        ap_upd,
    input  logic [7:0]  ap_sel,
    input  logic [5:0]  ap_addr,
    input  logic [31:0] ap_wdata,
    input  logic        ap_rnw,
    output logic        ap_busy,
    output logic [31:0] ap_rdata,
    output logic        ap_slverr,
    output logic [2:0]  ap_ack,
    jtag_mem_ap_if.master bus
);

    mem_ap_state_e state_q, state_d;
    csw_t          csw_q, csw_d;
    logic [31:0]   tar_q, tar_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          slverr_q, slverr_d;
    logic          busy_q;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          drw_q, drw_d;
    logic          ack_s;
    logic          accept;
    logic          is_bus;
    logic          timeout;
    logic [31:0]   reg_rdata;

    jtag_mem_ap_sync2 u_ack_sync (
        .clk   (tck),
        .rst_n (trstn),
        .d     (bus.m_ack),
        .q     (ack_s)
    );

`ifdef DBG_MEM_AP_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] cnt_q;

    // Counter is zero whenever the FSM is outside REQ, so it restarts on every new request.
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            cnt_q <= '0;
        end else if (state_q != StReq) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign timeout = (state_q == StReq) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    assign accept = ap_upd && (ap_sel == AP_SEL) && (state_q == StIdle);
    assign is_bus = (ap_addr == AddrDrw) || (ap_addr[5:2] == 4'b0001);

    always_comb begin
        reg_rdata = 32'd0;
        unique case (ap_addr)
            AddrCsw: reg_rdata = {23'd0, slverr_q, busy_q, 1'b1, csw_q.addrinc, 2'b00, csw_q.size};
            AddrTar: reg_rdata = tar_q;
            AddrIdr: reg_rdata = AP_IDR;
            default: reg_rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        csw_d    = csw_q;
        tar_d    = tar_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        req_d    = req_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        drw_d    = drw_q;
        unique case (state_q)
            StIdle: begin
                if (accept && is_bus) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    addr_d  = (ap_addr == AddrDrw) ? tar_q : {tar_q[31:4], ap_addr[1:0], 2'b00};
                    write_d = !ap_rnw;
                    size_d  = csw_q.size;
                    wdata_d = ap_wdata;
                    drw_d   = (ap_addr == AddrDrw);
                end else if (accept && ap_rnw) begin
                    rdata_d = reg_rdata;
                end else if (accept) begin
                    if (ap_addr == AddrCsw) begin
                        if (ap_wdata[1:0] != SizeRsvd) csw_d.size = ap_wdata[1:0];
                        csw_d.addrinc = ap_wdata[5:4];
                        if (ap_wdata[8]) slverr_d = 1'b0;
                    end else if (ap_addr == AddrTar) begin
                        tar_d = ap_wdata;
                    end
                end
            end
            StReq: begin
                if (ack_s) begin
                    state_d = StRel;
                    req_d   = 1'b0;
                    if (!write_q) rdata_d = bus.m_rdata;
                    if (bus.m_slverr) slverr_d = 1'b1;
                    if (drw_q && (csw_q.addrinc == IncSingle)) tar_d = tar_inc(tar_q, size_q);
                end else if (timeout) begin
                    state_d  = StRel;
                    req_d    = 1'b0;
                    slverr_d = 1'b1;
                    if (!write_q) rdata_d = AbortRdata;
                end
            end
            StRel: begin
                if (!ack_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            state_q  <= StIdle;
            csw_q    <= '0;
            tar_q    <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            wdata_q  <= '0;
            drw_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            csw_q    <= csw_d;
            tar_q    <= tar_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
            busy_q   <= (state_d != StIdle);
            req_q    <= req_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            drw_q    <= drw_d;
        end
    end

    assign ap_busy      = busy_q;
    assign ap_rdata     = rdata_q;
    assign ap_slverr    = slverr_q;
    assign ap_ack       = busy_q ? AckWait : AckOk;
    assign bus.m_req    = req_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_write  = write_q;
    assign bus.m_size   = size_q;
    assign bus.m_wdata  = wdata_q;

endmodule

// File: tb/tb_jtag_mem_ap.sv
// Directed bench for jtag_mem_ap: bridge model plus a scoreboard of expected bus requests.
module tb_jtag_mem_ap;

    localparam logic [7:0] SEL = 8'h00;

    logic        tck = 1'b0;
    logic        trstn = 1'b0;
    logic        ap_upd = 1'b0;
    logic [7:0]  ap_sel = 8'h00;
    logic [5:0]  ap_addr = 6'h00;
    logic [31:0] ap_wdata = 32'h0;
    logic        ap_rnw = 1'b0;
    logic        ap_busy;
    logic [31:0] ap_rdata;
    logic        ap_slverr;
    logic [2:0]  ap_ack;

    logic        bridge_en = 1'b1;
    logic [31:0] br_rdata = 32'h0;
    logic        br_slverr = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;

    jtag_mem_ap_if bus ();

    jtag_mem_ap #(
        .AP_SEL      (SEL),
        .AP_IDR      (32'h0477_0002),
        .TIMEOUT_CYC (16)
    ) dut (
        .tck       (tck),
        .trstn     (trstn),
        .ap_upd    (ap_upd),
        .ap_sel    (ap_sel),
        .ap_addr   (ap_addr),
        .ap_wdata  (ap_wdata),
        .ap_rnw    (ap_rnw),
        .ap_busy   (ap_busy),
        .ap_rdata  (ap_rdata),
        .ap_slverr (ap_slverr),
        .ap_ack    (ap_ack),
        .bus       (bus.master)
    );

    always #5 tck = ~tck;

    // Bridge: acknowledges one tck after seeing the request, releases when it is withdrawn.
    always @(posedge tck or negedge trstn) begin
        if (!trstn) bus.m_ack <= 1'b0;
        else        bus.m_ack <= bridge_en & bus.m_req;
    end
    assign bus.m_rdata  = br_rdata;
    assign bus.m_slverr = br_slverr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    always @(posedge bus.m_req) begin
        #1;
        if (exp_q.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
        end else begin
            mon_t = exp_q.pop_front();
            check("m_addr", bus.m_addr, mon_t.addr);
            check("m_write", {31'd0, bus.m_write}, {31'd0, mon_t.write});
            check("m_size", {30'd0, bus.m_size}, {30'd0, mon_t.size});
            if (mon_t.write) check("m_wdata", bus.m_wdata, mon_t.wdata);
        end
    end

    task automatic ap_access(input logic [7:0] sel, input logic [5:0] addr,
                             input logic [31:0] wdata, input logic rnw);
        @(negedge tck);
        ap_upd   = 1'b1;
        ap_sel   = sel;
        ap_addr  = addr;
        ap_wdata = wdata;
        ap_rnw   = rnw;
        @(negedge tck);
        ap_upd   = 1'b0;
        ap_sel   = SEL;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] wdata);
        ap_access(SEL, addr, wdata, 1'b0);
    endtask

    task automatic rd_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        ap_access(SEL, addr, 32'h0, 1'b1);
        check(tag, ap_rdata, exp);
    endtask

    task automatic push(input logic [31:0] addr, input logic write, input logic [1:0] size,
                        input logic [31:0] wdata);
        txn_t t;
        t.addr  = addr;
        t.write = write;
        t.size  = size;
        t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (!ap_busy) break;
            @(negedge tck);
        end
        check(tag, {31'd0, ap_busy}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge tck);
        check("rst_busy", {31'd0, ap_busy}, 32'd0);
        check("rst_ack", {29'd0, ap_ack}, 32'd2);
        check("rst_rdata", ap_rdata, 32'd0);
        check("rst_slverr", {31'd0, ap_slverr}, 32'd0);
        check("rst_m_req", {31'd0, bus.m_req}, 32'd0);
        check("rst_m_addr", bus.m_addr, 32'd0);
        check("rst_m_wdata", bus.m_wdata, 32'd0);
        trstn = 1'b1;

        // Word write with single auto-increment
        wr(6'h00, 32'h12);
        wr(6'h01, 32'h8000_0000);
        push(32'h8000_0000, 1'b1, 2'd2, 32'h1234_5678);
        wr(6'h03, 32'h1234_5678);
        wait_idle("idle_a");
        rd_check("tar_inc_a", 6'h01, 32'h8000_0004);
        rd_check("csw_a", 6'h00, 32'h52);

        // Read at the top of a 1 KB block wraps TAR[9:0]
        wr(6'h01, 32'h0000_03FC);
        br_rdata = 32'hCAFE_F00D;
        push(32'h0000_03FC, 1'b0, 2'd2, 32'h0);
        ap_access(SEL, 6'h03, 32'h0, 1'b1);
        wait_idle("idle_b");
        check("drw_rdata_b", ap_rdata, 32'hCAFE_F00D);
        rd_check("tar_wrap_b", 6'h01, 32'h0);

        // Accesses while busy and to another APSEL are ignored
        bridge_en = 1'b0;
        wr(6'h01, 32'h100);
        push(32'h100, 1'b1, 2'd2, 32'hA5);
        wr(6'h03, 32'hA5);
        repeat (3) @(negedge tck);
        check("busy_c", {31'd0, ap_busy}, 32'd1);
        check("ack_wait_c", {29'd0, ap_ack}, 32'd1);
        wr(6'h00, 32'h0);
        check("busy_c2", {31'd0, ap_busy}, 32'd1);
        bridge_en = 1'b1;
        wait_idle("idle_c");
        rd_check("csw_kept_c", 6'h00, 32'h52);
        rd_check("tar_inc_c", 6'h01, 32'h104);
        ap_access(8'h01, 6'h01, 32'hFFFF, 1'b0);
        ap_access(8'h01, 6'h00, 32'h0, 1'b1);
        check("sel_rd_ign_c", ap_rdata, 32'h104);
        rd_check("sel_wr_ign_c", 6'h01, 32'h104);

        // BD2 read with bus error
        wr(6'h01, 32'h1000_0004);
        br_rdata  = 32'h11;
        br_slverr = 1'b1;
        push(32'h1000_0008, 1'b0, 2'd2, 32'h0);
        ap_access(SEL, 6'h06, 32'h0, 1'b1);
        wait_idle("idle_d");
        br_slverr = 1'b0;
        check("slverr_d", {31'd0, ap_slverr}, 32'd1);
        check("bd_rdata_d", ap_rdata, 32'h11);
        rd_check("tar_bd_d", 6'h01, 32'h1000_0004);
        check("slverr_held_d", {31'd0, ap_slverr}, 32'd1);
        rd_check("csw_err_d", 6'h00, 32'h152);
        wr(6'h00, 32'h112);
        check("slverr_clr_d", {31'd0, ap_slverr}, 32'd0);

        // Reserved size, byte increment, addrinc off, IDR, unmapped offset
        wr(6'h00, 32'h13);
        rd_check("csw_rsvd_e", 6'h00, 32'h52);
        wr(6'h00, 32'h10);
        wr(6'h01, 32'h10);
        push(32'h10, 1'b1, 2'd0, 32'h77);
        wr(6'h03, 32'h77);
        wait_idle("idle_e");
        rd_check("tar_byte_e", 6'h01, 32'h11);
        wr(6'h00, 32'h02);
        wr(6'h01, 32'h20);
        push(32'h20, 1'b1, 2'd2, 32'h55);
        wr(6'h03, 32'h55);
        wait_idle("idle_e2");
        rd_check("tar_noinc_e", 6'h01, 32'h20);
        rd_check("idr_e", 6'h3F, 32'h0477_0002);
        rd_check("unmapped_e", 6'h02, 32'h0);

        // Stalled bridge: abort with timeout, otherwise wait forever
        wr(6'h00, 32'h12);
        wr(6'h01, 32'h40);
        bridge_en = 1'b0;
        push(32'h40, 1'b0, 2'd2, 32'h0);
        ap_access(SEL, 6'h03, 32'h0, 1'b1);
        n = 0;
        while (bus.m_req && n < 40) begin
            @(posedge tck);
            #1;
            n++;
        end
`ifdef DBG_MEM_AP_TIMEOUT_EN
        check("timeout_cycles", n, 32'd16);
        wait_idle("idle_f");
        check("timeout_slverr", {31'd0, ap_slverr}, 32'd1);
        check("timeout_rdata", ap_rdata, 32'hdead_dead);
        rd_check("timeout_tar", 6'h01, 32'h40);
        push(32'h40, 1'b0, 2'd2, 32'h0);
        ap_access(SEL, 6'h03, 32'h0, 1'b1);
        repeat (2) @(negedge tck);
`else
        check("stall_busy", {31'd0, ap_busy}, 32'd1);
        check("stall_m_req", {31'd0, bus.m_req}, 32'd1);
`endif

        // Asynchronous reset in REQ takes effect without a tck edge
        check("pre_rst_busy", {31'd0, ap_busy}, 32'd1);
        @(negedge tck);
        #2;
        trstn = 1'b0;
        #1;
        check("arst_m_req", {31'd0, bus.m_req}, 32'd0);
        check("arst_busy", {31'd0, ap_busy}, 32'd0);
        check("arst_ack", {29'd0, ap_ack}, 32'd2);
        check("arst_m_addr", bus.m_addr, 32'd0);
        @(negedge tck);
        trstn = 1'b1;
        bridge_en = 1'b1;
        rd_check("arst_tar", 6'h01, 32'h0);
        rd_check("arst_csw", 6'h00, 32'h40);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
